// File: rtl/march_element_sequencer_pkg.sv
// march_element_sequencer_pkg: shared address-mode codes, element lengths and sequencer state encoding.
package march_element_sequencer_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int IR_BFW_ADMD = 3;
  localparam logic ADDR_UP = 1'b0;
  localparam logic [IR_BFW_ADMD-1:0] ADMD_LIN = 3'd0;
  localparam logic [IR_BFW_ADMD-1:0] ADMD_PRUD = 3'd1;
  localparam logic [IR_BFW_ADMD-1:0] ADMD_GRAY = 3'd2;
  localparam logic [IR_BFW_ADMD-1:0] ADMD_ROW = 3'd3;
  localparam int MES_N_LIN = 256;
  localparam int MES_N_PR = 255;
  typedef enum logic [1:0] {MES_IDLE, MES_LOAD, MES_RUN, MES_DONE} mes_state_t;
  function automatic int mes_len(input logic [IR_BFW_ADMD-1:0] admd);
    return (admd == ADMD_PRUD) ? MES_N_PR : MES_N_LIN;
  endfunction
endpackage

// File: rtl/march_element_sequencer_step_counter.sv
// mes_step_counter: loadable down counter of remaining addresses with a zero flag.
module mes_step_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (ld) cnt <= val;
    else if (en) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/march_element_sequencer.sv
// march_element_sequencer: steps one march element through all addresses and op slots.
// Define MES_ABORT_EN to add the abort_in/aborted_out element abort.
module march_element_sequencer
  import march_element_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int ADMW = IR_BFW_ADMD,
  parameter int OPW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [ADMW-1:0] admd_in,
  input  logic            updwn_in,
  input  logic [OPW-1:0]  nops_in,
  input  logic            pause_in,
  output logic            s_out,
  output logic            r_out,
  output logic            hold_out,
  output logic            updwn_out,
  output logic [OPW-1:0]  op_idx_out,
  output logic            op_valid_out,
  output logic            last_addr_out,
  output logic            busy_out,
  output logic            done_out
`ifdef MES_ABORT_EN
  ,
  input  logic            abort_in,
  output logic            aborted_out
`endif
);
  mes_state_t state, state_nxt;
  logic upd, step_ld, step_en, step_zero, abort_hit;
  logic [OPW-1:0] nops, op_idx, op_nxt;
  mes_step_counter #(.W(ADDR_W)) u_step (
    .clk(clk),
    .rst(rst),
    .ld(step_ld),
    .en(step_en),
    .val(ADDR_W'(mes_len(admd_in) - 1)),
    .zero(step_zero)
  );
`ifdef MES_ABORT_EN
  assign abort_hit = abort_in && state != MES_IDLE;
  always_ff @(posedge clk) aborted_out <= !rst && abort_hit;
`else
  assign abort_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MES_IDLE;
      op_idx <= '0;
      upd <= 1'b0;
      nops <= '0;
    end else begin
      state <= state_nxt;
      op_idx <= op_nxt;
      if (step_ld) begin
        upd <= updwn_in;
        nops <= nops_in;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    op_nxt = op_idx;
    step_ld = 1'b0;
    step_en = 1'b0;
    hold_out = 1'b1;
    op_valid_out = 1'b0;
    case (state)
      MES_IDLE: if (start_in) begin
        step_ld = 1'b1;
        op_nxt = '0;
        state_nxt = MES_LOAD;
      end
      MES_LOAD: begin
        hold_out = 1'b0;
        state_nxt = MES_RUN;
      end
      MES_RUN: if (!pause_in) begin
        op_valid_out = 1'b1;
        if (op_idx != nops) op_nxt = op_idx + 1'b1;
        else if (step_zero) state_nxt = MES_DONE;
        else begin
          hold_out = 1'b0;
          op_nxt = '0;
          step_en = 1'b1;
        end
      end
      default: state_nxt = MES_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = MES_IDLE;
      step_en = 1'b0;
      hold_out = 1'b1;
    end
  end
  assign s_out = state == MES_LOAD && upd == ADDR_UP;
  assign r_out = state == MES_LOAD && upd != ADDR_UP;
  assign updwn_out = state != MES_IDLE && upd;
  assign op_idx_out = state == MES_RUN ? op_idx : '0;
  assign last_addr_out = state == MES_RUN && step_zero;
  assign busy_out = state == MES_LOAD || state == MES_RUN;
  assign done_out = state == MES_DONE;
endmodule

// File: tb/tb_march_element_sequencer.sv
// tb_march_element_sequencer: table-driven element runs plus reset, restart and abort sequences.
module tb_march_element_sequencer;
  import march_element_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst, start_in, updwn_in, pause_in;
  logic [2:0] admd_in;
  logic [1:0] nops_in;
  logic s_out, r_out, hold_out, updwn_out, op_valid_out, last_addr_out, busy_out, done_out;
  logic [1:0] op_idx_out;
`ifdef MES_ABORT_EN
  logic abort_in = 1'b0;
  logic aborted_out;
`endif
  int checks = 0;
  int fails = 0;
  march_element_sequencer dut (
    .clk(clk), .rst(rst), .start_in(start_in), .admd_in(admd_in), .updwn_in(updwn_in),
    .nops_in(nops_in), .pause_in(pause_in), .s_out(s_out), .r_out(r_out), .hold_out(hold_out),
    .updwn_out(updwn_out), .op_idx_out(op_idx_out), .op_valid_out(op_valid_out),
    .last_addr_out(last_addr_out), .busy_out(busy_out), .done_out(done_out)
`ifdef MES_ABORT_EN
    , .abort_in(abort_in), .aborted_out(aborted_out)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] admd;
    logic upd;
    logic [1:0] nops;
    int pause_at;
    int pause_len;
    int restart_at;
    int exp_slots;
    int exp_len;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    chk({tag, ".s"}, 32'(s_out), 0);
    chk({tag, ".r"}, 32'(r_out), 0);
    chk({tag, ".hold"}, 32'(hold_out), 1);
    chk({tag, ".updwn"}, 32'(updwn_out), 0);
    chk({tag, ".op_idx"}, 32'(op_idx_out), 0);
    chk({tag, ".op_valid"}, 32'(op_valid_out), 0);
    chk({tag, ".last"}, 32'(last_addr_out), 0);
    chk({tag, ".busy"}, 32'(busy_out), 0);
    chk({tag, ".done"}, 32'(done_out), 0);
  endtask
  task automatic run_elem(input vec_t v);
    int n, cyc, addr, op, slots, pleft;
    bit ptrig, p;
    n = (v.admd == ADMD_PRUD) ? 255 : 256;
    admd_in = v.admd;
    updwn_in = v.upd;
    nops_in = v.nops;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    admd_in = ~v.admd;
    updwn_in = ~v.upd;
    nops_in = ~v.nops;
    #1;
    chk("load.s", 32'(s_out), 32'(!v.upd));
    chk("load.r", 32'(r_out), 32'(v.upd));
    chk("load.hold", 32'(hold_out), 0);
    chk("load.busy", 32'(busy_out), 1);
    chk("load.updwn", 32'(updwn_out), 32'(v.upd));
    chk("load.op_valid", 32'(op_valid_out), 0);
    chk("load.last", 32'(last_addr_out), 0);
    cyc = 1;
    addr = 0;
    op = 0;
    slots = 0;
    pleft = 0;
    ptrig = 0;
    while (addr < n && cyc < 3000) begin
      tick();
      cyc++;
      if (!ptrig && slots == v.pause_at) begin
        ptrig = 1;
        pleft = v.pause_len;
      end
      p = pleft > 0;
      pause_in = p;
      start_in = slots == v.restart_at;
      #1;
      chk("run.op_valid", 32'(op_valid_out), 32'(!p));
      chk("run.hold", 32'(hold_out), 32'(p || op != v.nops || addr == n - 1));
      chk("run.op_idx", 32'(op_idx_out), 32'(op));
      chk("run.last", 32'(last_addr_out), 32'(addr == n - 1));
      chk("run.busy", 32'(busy_out), 1);
      chk("run.updwn", 32'(updwn_out), 32'(v.upd));
      chk("run.done", 32'(done_out), 0);
      if (p) pleft--;
      else begin
        slots++;
        if (op == v.nops) begin
          op = 0;
          addr++;
        end else op++;
      end
    end
    pause_in = 1'b0;
    start_in = 1'b0;
    tick();
    cyc++;
    chk("done.done", 32'(done_out), 1);
    chk("done.busy", 32'(busy_out), 0);
    chk("done.hold", 32'(hold_out), 1);
    chk("done.updwn", 32'(updwn_out), 32'(v.upd));
    chk("done.len", 32'(cyc), 32'(v.exp_len));
    chk("done.slots", 32'(slots), 32'(v.exp_slots));
    tick();
    check_idle("after_done");
  endtask
  initial begin
    vecs[0] = '{ADMD_LIN, 1'b0, 2'd0, -1, 0, -1, 256, 258};
    vecs[1] = '{ADMD_LIN, 1'b1, 2'd2, -1, 0, -1, 768, 770};
    vecs[2] = '{ADMD_PRUD, 1'b0, 2'd0, -1, 0, -1, 255, 257};
    vecs[3] = '{ADMD_LIN, 1'b0, 2'd1, 10, 3, -1, 512, 517};
    vecs[4] = '{ADMD_PRUD, 1'b1, 2'd3, -1, 0, 5, 1020, 1022};
    rst = 1'b1;
    start_in = 1'b0;
    pause_in = 1'b0;
    admd_in = ADMD_LIN;
    updwn_in = 1'b0;
    nops_in = 2'd0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    pause_in = 1'b1;
    #1;
    check_idle("idle_pause");
    pause_in = 1'b0;
    for (int i = 0; i < 5; i++) run_elem(vecs[i]);
    admd_in = ADMD_LIN;
    updwn_in = 1'b1;
    nops_in = 2'd0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (51) tick();
    chk("mid.busy", 32'(busy_out), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_idle("rst_mid");
    tick();
    chk("rst_mid.stay_idle", 32'(busy_out), 0);
    run_elem(vecs[0]);
`ifdef MES_ABORT_EN
    chk("abort.reset", 32'(aborted_out), 0);
    admd_in = ADMD_LIN;
    updwn_in = 1'b0;
    nops_in = 2'd0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (21) tick();
    abort_in = 1'b1;
    pause_in = 1'b1;
    tick();
    abort_in = 1'b0;
    pause_in = 1'b0;
    #1;
    check_idle("abort");
    chk("abort.pulse", 32'(aborted_out), 1);
    tick();
    chk("abort.pulse_end", 32'(aborted_out), 0);
    chk("abort.no_done", 32'(done_out), 0);
    run_elem(vecs[2]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/march_element_sequencer.md
# march_element_sequencer

Drives one march element of a PMBIST test. It issues the first/last-address load, hold and up/down commands to the address counter, then steps through every address of the selected address mode. At each address it presents a programmable number of operation slots to the read/write data path, and it pulses done when the element completes. It sits between the instruction decoder (start, element fields) and the address counter (s, r, hold, updwn).

## Interface
- ADDR_W, 8, address width; must match the address counter.
- ADMW, `IR_BFW_ADMD`, address-mode field width.
- OPW, 2, op-index width (up to 2^OPW ops per address).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_in  in  1  element start pulse; sampled only in IDLE
- admd_in  in  ADMW  address mode; latched at start
- updwn_in  in  1  element direction, `ADDR_UP`=0 / down=1; latched at start
- nops_in  in  OPW  ops per address minus one; latched at start
- pause_in  in  1  stall request from the data path
- s_out  out  1  load first address
- r_out  out  1  load last address
- hold_out  out  1  freeze address counter
- updwn_out  out  1  counter direction
- op_idx_out  out  OPW  current op slot at current address
- op_valid_out  out  1  op slot active this cycle
- last_addr_out  out  1  current address is the final address of the element
- busy_out  out  1  element in progress
- done_out  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - hold_out=1.
  - On start_in=1, latch admd/updwn/nops, load step counter with N-1, go to LOAD.
  - N=255 when admd=`ADMD_PRUD`, else N=256.
- LOAD (1 cycle):
  - s_out=1 if latched updwn=0, else r_out=1.
  - hold_out=0, op_idx=0. Go to RUN.
- RUN:
  - op_valid_out=1 unless pause_in.
  - hold_out=1 while op_idx<nops. On op_idx==nops, hold_out=0 (counter advances), op_idx returns to 0 and the step counter decrements.
  - When op_idx==nops and step==0, go to DONE instead; hold_out stays 1 in that cycle.
- pause_in=1 in RUN: op_valid_out=0, hold_out=1, op_idx and step frozen. Pause in IDLE/LOAD/DONE is ignored.
- DONE (1 cycle): done_out=1, busy=0, then IDLE.
- updwn_out equals the latched direction from LOAD through DONE, and 0 in IDLE.
- last_addr_out=1 in RUN when step==0.
- busy_out=1 in LOAD and RUN.
- start_in outside IDLE is ignored. Field changes after start have no effect.
- rst in any state → IDLE next edge, all outputs to reset values.
- Reset values: s_out=0, r_out=0, hold_out=1, updwn_out=0, op_idx_out=0, op_valid_out=0, last_addr_out=0, busy_out=0, done_out=0.
- All outputs are registered, except hold_out/op_valid_out, which combine registered state with pause_in.

## Timing
- Start sampled at edge k → LOAD during cycle k+1. The counter shows the first address at cycle k+2, which is also the first RUN cycle, so op slots align with tas.
- Element length without pause: 1 (LOAD) + N·(nops+1) RUN cycles + 1 DONE cycle.
- The next start is accepted the cycle after DONE.
- Each pause cycle extends RUN by exactly one cycle.

## Configuration
- MES_ABORT_EN defined: adds port abort_in (in, 1) and aborted_out (out, 1, pulse, reset 0).
  - abort_in=1 in LOAD/RUN/DONE → IDLE at the next edge with aborted_out=1 for one cycle.
  - No done_out is issued and hold_out=1.
  - abort has priority over pause; rst has priority over abort.
- Undefined: ports absent; behaviour as above.

## Structure
- Shared defines file holds:
  - `ADMD_*` codes, `ADDR_UP`, `ADDR_WIDTH`, `IR_BFW_ADMD`.
  - State encodings (`MES_IDLE`, `MES_LOAD`, `MES_RUN`, `MES_DONE`).
  - Element lengths `MES_N_LIN`=256 and `MES_N_PR`=255.
- One sub-module, mes_step_counter: loadable ADDR_W-bit down counter with enable and a zero flag.

## Test plan
- Linear up, nops=0, start at edge 0: s_out=1 cycle 1; op_valid=1 and hold_out=0 cycles 2–257; last_addr_out cycle 257; done_out cycle 258.
- Linear down, nops=2: r_out=1 in LOAD; 768 op slots with op_idx 0,1,2 repeating; hold_out=1,1,0 per address; done after 770 cycles.
- `ADMD_PRUD`, nops=0: exactly 255 op slots; last_addr_out on slot 255.
- pause_in high 3 cycles at slot 10 (nops=1): op_idx frozen, hold_out=1, op_valid=0; done delayed by exactly 3 cycles.
- start_in re-asserted during RUN is ignored.
- rst at slot 50: all outputs at reset values the next cycle; a fresh start runs a full element.
- MES_ABORT_EN: abort_in at slot 20 → IDLE next cycle, aborted_out=1 for 1 cycle, no done_out.
